// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the byte-serial memory controller: FSM states,
// IO region base and fetch word geometry.
package riscv_mem_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSlbAcc,
        StSlbDone,
        StIfIssue,
        StIfDrain
    } mem_state_t;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;
    localparam int unsigned BYTES_PER_WORD  = 4;
    localparam int unsigned IDX_W           = $clog2(BYTES_PER_WORD);
    localparam int unsigned WORD_W          = 8 * BYTES_PER_WORD;

endpackage

// File: rtl/mem_if_assembler.sv
// Instruction word assembler: issue-side byte index plus the byte placement
// register. Returned data lags the issued address by one cycle.
module mem_if_assembler
    import riscv_mem_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              start,
    input  logic              issue,
    input  logic              capture,
    input  logic              abort,
    input  logic [7:0]        byte_in,
    output logic [IDX_W-1:0]  idx,
    output logic [WORD_W-1:0] word,
    output logic [WORD_W-1:0] word_next
);

    logic [IDX_W-1:0]  idx_q, idx_d, slot;
    logic [WORD_W-1:0] word_q, word_d;

    // The byte arriving now belongs to the address issued one cycle earlier;
    // in the drain cycle the index has wrapped to 0, so slot lands on the top byte.
    assign slot = idx_q - IDX_W'(1);

    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        if (start || abort) begin
            idx_d  = '0;
            word_d = '0;
        end else begin
            if (capture) begin
                word_d[{slot, 3'b000} +: 8] = byte_in;
            end
            if (issue) begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            idx_q  <= '0;
            word_q <= '0;
        end else if (rdy_in) begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

    assign idx       = idx_q;
    assign word      = word_q;
    assign word_next = word_d;

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial RAM/IO responder arbitrating SLB byte accesses over 4-byte fetches.
// Optional MEM_CTRL_IO_STALL_EN holds IO-region writes while io_buffer_full is set.
module mem_ctrl
    import riscv_mem_pkg::*;
#(
    parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        slb_req,
    input  logic        slb_wr,
    input  logic [31:0] slb_addr,
    input  logic [7:0]  slb_wdata,
    output logic        slb_valid,
    output logic [7:0]  slb_rdata,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_valid,
    output logic [31:0] if_inst,
    input  logic        clear,
    input  logic        io_buffer_full,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr
);

    mem_state_t  state_q, state_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic [7:0]  slb_rdata_q, slb_rdata_d;
    logic        mem_wr_q, mem_wr_d;
    logic        slb_wr_q, slb_wr_d;

    logic              asm_start, asm_issue, asm_capture, asm_abort;
    logic [IDX_W-1:0]  asm_idx;
    logic [WORD_W-1:0] asm_word, asm_word_next;
    logic              io_stall;

`ifdef MEM_CTRL_IO_STALL_EN
    assign io_stall = slb_wr && (slb_addr >= IO_BASE) && io_buffer_full;
`else
    logic unused_io_stall;
    assign io_stall        = 1'b0;
    assign unused_io_stall = io_buffer_full & (slb_addr >= IO_BASE);
`endif

    always_comb begin
        state_d     = state_q;
        mem_a_d     = mem_a_q;
        mem_dout_d  = mem_dout_q;
        mem_wr_d    = mem_wr_q;
        slb_wr_d    = slb_wr_q;
        slb_rdata_d = slb_rdata_q;
        asm_start   = 1'b0;
        asm_issue   = 1'b0;
        asm_capture = 1'b0;
        asm_abort   = 1'b0;
        slb_valid   = 1'b0;
        if_valid    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (slb_req) begin
                    // A stalled IO write keeps priority; the fetch waits behind it.
                    if (!io_stall) begin
                        mem_a_d    = slb_addr;
                        mem_wr_d   = slb_wr;
                        mem_dout_d = slb_wdata;
                        slb_wr_d   = slb_wr;
                        state_d    = StSlbAcc;
                    end
                end else if (if_req && !clear) begin
                    mem_a_d   = if_addr;
                    asm_start = 1'b1;
                    state_d   = StIfIssue;
                end
            end
            StSlbAcc: begin
                mem_wr_d = 1'b0;
                state_d  = StSlbDone;
            end
            StSlbDone: begin
                slb_valid = 1'b1;
                if (!slb_wr_q) begin
                    slb_rdata_d = mem_din;
                end
                state_d = StIdle;
            end
            StIfIssue: begin
                if (clear) begin
                    asm_abort = 1'b1;
                    state_d   = StIdle;
                end else begin
                    asm_issue   = 1'b1;
                    asm_capture = (asm_idx != '0);
                    if (asm_idx == IDX_W'(BYTES_PER_WORD - 1)) begin
                        state_d = StIfDrain;
                    end else begin
                        mem_a_d = mem_a_q + 32'd1;
                    end
                end
            end
            StIfDrain: begin
                if (clear) begin
                    asm_abort = 1'b1;
                end else begin
                    asm_capture = 1'b1;
                    if_valid    = 1'b1;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= StIdle;
            mem_a_q     <= '0;
            mem_dout_q  <= '0;
            mem_wr_q    <= 1'b0;
            slb_wr_q    <= 1'b0;
            slb_rdata_q <= '0;
        end else if (rdy_in) begin
            state_q     <= state_d;
            mem_a_q     <= mem_a_d;
            mem_dout_q  <= mem_dout_d;
            mem_wr_q    <= mem_wr_d;
            slb_wr_q    <= slb_wr_d;
            slb_rdata_q <= slb_rdata_d;
        end
    end

    mem_if_assembler u_if_asm (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .rdy_in    (rdy_in),
        .start     (asm_start),
        .issue     (asm_issue),
        .capture   (asm_capture),
        .abort     (asm_abort),
        .byte_in   (mem_din),
        .idx       (asm_idx),
        .word      (asm_word),
        .word_next (asm_word_next)
    );

    // Read byte and final fetch byte arrive in the pulse cycle, so both are
    // forwarded from next-state and held in the registers afterwards.
    assign slb_rdata = slb_rdata_d;
    assign if_inst   = if_valid ? asm_word_next : asm_word;
    assign mem_a     = mem_a_q;
    assign mem_dout  = mem_dout_q;
    assign mem_wr    = mem_wr_q & rdy_in;

endmodule
